qbus_dma_arb: RTL and testbench

QBUS_DMA_ARB -- requirements
Module: qbus_dma_arb

---
 rtl/qbus_pkg.sv | 22 ++
 rtl/rr_pick.sv | 31 +++
 rtl/qbus_dma_arb.sv | 98 +++++++++
 tb/tb_qbus_dma_arb.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/qbus_pkg.sv
// Shared QBUS arbiter definitions: FSM state encodings, default sizing, index helper.
package qbus_pkg;

    localparam int unsigned NDEV_DEFAULT = 4;
    localparam int unsigned TMO_DEFAULT  = 64;
    localparam int unsigned IDX_W        = 3;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_ARB   = 3'd1,
        ST_GRANT = 3'd2,
        ST_OWN   = 3'd3,
        ST_REL   = 3'd4
    } qbus_state_t;

    // Next device index, wrapping at n.
    function automatic logic [IDX_W-1:0] idx_inc(input logic [IDX_W-1:0] idx,
                                                 input int unsigned n);
        return (32'(idx) + 1 >= n) ? '0 : idx + 1'b1;
    endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first set req at or above rr, wrapping modulo NDEV.
module rr_pick
    import qbus_pkg::*;
#(
    parameter int unsigned NDEV = NDEV_DEFAULT
) (
    input  logic [NDEV-1:0]  req,
    input  logic [IDX_W-1:0] rr,
    output logic [IDX_W-1:0] winner
);

    logic [7:0]       req_ext;
    logic [IDX_W-1:0] idx;
    logic             found;

    assign req_ext = 8'(req);

    always_comb begin
        winner = rr;
        found  = 1'b0;
        idx    = '0;
        for (int unsigned i = 0; i < NDEV; i++) begin
            idx = IDX_W'((32'(rr) + i) % NDEV);
            if (!found && req_ext[idx]) begin
                winner = idx;
                found  = 1'b1;
            end
        end
    end

endmodule

// File: rtl/qbus_dma_arb.sv
// QBUS DMA arbiter: collects device requests, negotiates DMR/DMGO/SACK with the CPU
// and hands bus mastership to one device at a time in round-robin order.
module qbus_dma_arb
    import qbus_pkg::*;
#(
    parameter int unsigned NDEV = NDEV_DEFAULT,
    parameter int unsigned TMO  = TMO_DEFAULT
) (
    input  logic             pin_clk,
    input  logic             pin_rst,
    input  logic [NDEV-1:0]  req,
    input  logic [NDEV-1:0]  sack,
    output logic [NDEV-1:0]  gnt,
    output logic             pin_dmr_n,
    input  logic             pin_dmgo_n,
    output logic             pin_sack_n,
    input  logic             pin_sync_n,
    input  logic             pin_rply_n,
    output logic [IDX_W-1:0] owner,
    output logic             busy,
    output logic             tmo
);

    qbus_state_t      state, state_nx;
    logic [IDX_W-1:0] rr;
    logic [IDX_W-1:0] winner;
    logic [7:0]       cnt;
    logic [7:0]       sack_ext;
    logic             sack_own;
    logic             tmo_hit;

    rr_pick #(.NDEV(NDEV)) u_pick (
        .req    (req),
        .rr     (rr),
        .winner (winner)
    );

    // Only the acknowledge of the current owner is ever looked at.
    assign sack_ext = 8'(sack);
    assign sack_own = sack_ext[owner];
    assign tmo_hit  = (state == ST_GRANT) && !sack_own && (cnt == 8'(TMO - 1));

    always_ff @(posedge pin_clk) begin
        if (pin_rst) begin
            state <= ST_IDLE;
            owner <= '0;
            rr    <= '0;
            cnt   <= '0;
        end else begin
            state <= state_nx;
            if (state == ST_ARB && state_nx == ST_GRANT) begin
                owner <= winner;
                cnt   <= '0;
            end else if (state == ST_GRANT) begin
                cnt <= cnt + 8'd1;
            end
            if (state == ST_REL) begin
                rr <= idx_inc(owner, NDEV);
            end
        end
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            ST_IDLE: begin
                if (|req) state_nx = ST_ARB;
            end
            ST_ARB: begin
                if (!(|req))          state_nx = ST_IDLE;
                else if (!pin_dmgo_n) state_nx = ST_GRANT;
            end
            ST_GRANT: begin
                if (sack_own)        state_nx = ST_OWN;
                else if (tmo_hit)    state_nx = ST_REL;
                else if (pin_dmgo_n) state_nx = ST_IDLE;
            end
            ST_OWN: begin
                if (!sack_own && pin_sync_n && pin_rply_n) state_nx = ST_REL;
            end
            ST_REL:  state_nx = ST_IDLE;
            default: state_nx = ST_IDLE;
        endcase
    end

    // Outputs decode directly from state so reset releases the bus on the next clock.
    always_comb begin
        gnt        = '0;
        pin_dmr_n  = !((state == ST_ARB) || (state == ST_GRANT));
        pin_sack_n = (state != ST_OWN);
        busy       = (state != ST_IDLE);
        tmo        = tmo_hit;
        for (int unsigned i = 0; i < NDEV; i++) begin
            gnt[i] = (state == ST_GRANT) && (owner == IDX_W'(i));
        end
    end

endmodule

// File: tb/tb_qbus_dma_arb.sv
// Directed bench for qbus_dma_arb; expected owners queue up when requests are
// driven and are checked when the grant appears.
module tb_qbus_dma_arb;

    localparam int unsigned NDEV = 4;
    localparam int unsigned TMO  = 64;

    logic            pin_clk = 1'b0;
    logic            pin_rst;
    logic [NDEV-1:0] req;
    logic [NDEV-1:0] sack;
    logic [NDEV-1:0] gnt;
    logic            pin_dmr_n;
    logic            pin_dmgo_n;
    logic            pin_sack_n;
    logic            pin_sync_n;
    logic            pin_rply_n;
    logic [2:0]      owner;
    logic            busy;
    logic            tmo;

    int          checks   = 0;
    int          failures = 0;
    int unsigned exp_q[$];
    int unsigned n, tpos, tcnt;

    always #5 pin_clk = ~pin_clk;

    qbus_dma_arb #(.NDEV(NDEV), .TMO(TMO)) dut (
        .pin_clk    (pin_clk),
        .pin_rst    (pin_rst),
        .req        (req),
        .sack       (sack),
        .gnt        (gnt),
        .pin_dmr_n  (pin_dmr_n),
        .pin_dmgo_n (pin_dmgo_n),
        .pin_sack_n (pin_sack_n),
        .pin_sync_n (pin_sync_n),
        .pin_rply_n (pin_rply_n),
        .owner      (owner),
        .busy       (busy),
        .tmo        (tmo)
    );

    task automatic tick();
        @(posedge pin_clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        pin_rst = 1'b1;
        tick();
        tick();
        pin_rst = 1'b0;
    endtask

    task automatic wait_grant();
        int unsigned cyc;
        int unsigned e;
        cyc = 0;
        do begin
            tick();
            cyc++;
        end while (gnt == '0 && cyc < 8);
        chk("grant_latency", cyc, 1);
        e = (exp_q.size() != 0) ? exp_q.pop_front() : 32'd99;
        chk("owner", 32'(owner), e);
        chk("gnt_onehot", 32'(gnt), 32'(1) << e);
    endtask

    // Full ownership: request, CPU grant, device SACK, release with optional busy bus.
    task automatic serve(input logic [NDEV-1:0] r, input int unsigned e,
                         input bit hold, input int unsigned busy_clks);
        pin_dmgo_n = 1'b1;
        req        = r;
        exp_q.push_back(e);
        tick();
        chk("arb_dmr_n", 32'(pin_dmr_n), 0);
        chk("arb_gnt", 32'(gnt), 0);
        repeat (3) tick();
        chk("arb_wait_dmr_n", 32'(pin_dmr_n), 0);
        pin_dmgo_n = 1'b0;
        wait_grant();
        if (!hold) req = '0;
        sack = NDEV'(32'(1) << e);
        tick();
        chk("own_sack_n", 32'(pin_sack_n), 0);
        chk("own_dmr_n", 32'(pin_dmr_n), 1);
        chk("own_gnt", 32'(gnt), 0);
        pin_dmgo_n = 1'b1;
        sack       = '0;
        if (busy_clks != 0) pin_rply_n = 1'b0;
        for (int unsigned i = 0; i < busy_clks; i++) begin
            tick();
            chk("own_bus_active", 32'(pin_sack_n), 0);
        end
        pin_rply_n = 1'b1;
        tick();
        chk("rel_sack_n", 32'(pin_sack_n), 1);
        chk("rel_gnt", 32'(gnt), 0);
        chk("rel_busy", 32'(busy), 1);
        tick();
        chk("idle_busy", 32'(busy), 0);
        chk("idle_dmr_n", 32'(pin_dmr_n), 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        pin_rst    = 1'b1;
        req        = '0;
        sack       = '0;
        pin_dmgo_n = 1'b1;
        pin_sync_n = 1'b1;
        pin_rply_n = 1'b1;
        tick();
        tick();
        chk("rst_gnt", 32'(gnt), 0);
        chk("rst_dmr_n", 32'(pin_dmr_n), 1);
        chk("rst_sack_n", 32'(pin_sack_n), 1);
        chk("rst_owner", 32'(owner), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_tmo", 32'(tmo), 0);
        pin_rst = 1'b0;

        // Single device, then rr=1 must favour device 1 over device 0.
        serve(4'b0001, 0, 1'b0, 0);
        serve(4'b0011, 1, 1'b0, 0);

        // Fairness with all requests held; fifth grant shows the wrap.
        do_reset();
        serve(4'b1111, 0, 1'b1, 0);
        serve(4'b1111, 1, 1'b1, 0);
        serve(4'b1111, 2, 1'b1, 0);
        serve(4'b1111, 3, 1'b1, 0);
        serve(4'b1111, 0, 1'b0, 0);

        // CPU withdraws DMGO during GRANT: back to IDLE with rr still 1.
        req = 4'b0001;
        tick();
        pin_dmgo_n = 1'b0;
        exp_q.push_back(0);
        wait_grant();
        pin_dmgo_n = 1'b1;
        req        = '0;
        tick();
        chk("abort_gnt", 32'(gnt), 0);
        chk("abort_busy", 32'(busy), 0);
        chk("abort_dmr_n", 32'(pin_dmr_n), 1);
        serve(4'b1111, 1, 1'b0, 0);

        // Timeout on device 2 while every other device raises sack.
        do_reset();
        req = 4'b0100;
        tick();
        chk("tmo_arb_dmr_n", 32'(pin_dmr_n), 0);
        sack       = 4'b1011;
        pin_dmgo_n = 1'b0;
        exp_q.push_back(2);
        wait_grant();
        n    = 0;
        tpos = 0;
        tcnt = 0;
        while (gnt != '0 && n < 200) begin
            n++;
            if (tmo) begin
                tcnt++;
                tpos = n;
            end
            tick();
        end
        chk("tmo_pos", tpos, TMO);
        chk("tmo_count", tcnt, 1);
        chk("grant_clocks", n, TMO);
        chk("tmo_rel_tmo", 32'(tmo), 0);
        chk("tmo_rel_busy", 32'(busy), 1);
        chk("tmo_rel_sack_n", 32'(pin_sack_n), 1);
        req        = '0;
        sack       = '0;
        pin_dmgo_n = 1'b1;
        tick();
        chk("tmo_idle_busy", 32'(busy), 0);
        serve(4'b1111, 3, 1'b0, 0);

        // Bus still active after sack drops.
        serve(4'b0010, 1, 1'b0, 3);

        // Request withdrawn in ARB.
        req = 4'b1000;
        tick();
        chk("wd_arb_dmr_n", 32'(pin_dmr_n), 0);
        req = '0;
        tick();
        chk("wd_dmr_n", 32'(pin_dmr_n), 1);
        chk("wd_busy", 32'(busy), 0);
        chk("wd_gnt", 32'(gnt), 0);
        tick();
        chk("wd_gnt_later", 32'(gnt), 0);

        // Reset in the middle of OWN.
        req = 4'b0001;
        tick();
        pin_dmgo_n = 1'b0;
        exp_q.push_back(0);
        wait_grant();
        req  = '0;
        sack = 4'b0001;
        tick();
        chk("mid_own_sack_n", 32'(pin_sack_n), 0);
        pin_rst = 1'b1;
        tick();
        pin_rst    = 1'b0;
        sack       = '0;
        pin_dmgo_n = 1'b1;
        chk("prst_sack_n", 32'(pin_sack_n), 1);
        chk("prst_dmr_n", 32'(pin_dmr_n), 1);
        chk("prst_gnt", 32'(gnt), 0);
        chk("prst_owner", 32'(owner), 0);
        chk("prst_busy", 32'(busy), 0);
        chk("prst_tmo", 32'(tmo), 0);
        serve(4'b0010, 1, 1'b0, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
